// File: rtl/pc_redirect_unit_pkg.sv
// Shared types and helpers for the fetch-stage PC redirect unit.
package pc_redirect_unit_pkg;

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_SQUASH  = 2'd1,
        S_TRAP    = 2'd2,
        S_HALTED  = 2'd3
    } state_t;

    localparam int unsigned PC_INC = 4;

    // A redirect target must be word aligned and fit inside the PC width.
    function automatic logic is_legal_target(input logic [31:0] target, input int unsigned pc_w);
        return (target[1:0] == 2'b00) && ((target >> pc_w) == 32'd0);
    endfunction

endpackage

// File: rtl/pc_redirect_unit_if.sv
// Branch-resolution inputs and fetch-control outputs of the PC redirect unit.
interface pc_redirect_unit_if #(
    parameter int unsigned PC_W  = 9,
    parameter int unsigned CNT_W = 16
);
    logic             PcSel;
    logic [31:0]      BrPC;
    logic             Stall;
    logic             Halt;
    logic             imem_ready;
    logic [PC_W-1:0]  Cur_PC;
    logic             Fetch_Valid;
    logic             Flush_IFID;
    logic             Flush_IDEX;
    logic             Trap;
    logic             Halted;
    logic [CNT_W-1:0] Redirect_Cnt;

    modport master (
        output PcSel, BrPC, Stall, Halt, imem_ready,
        input  Cur_PC, Fetch_Valid, Flush_IFID, Flush_IDEX, Trap, Halted, Redirect_Cnt
    );

    modport slave (
        input  PcSel, BrPC, Stall, Halt, imem_ready,
        output Cur_PC, Fetch_Valid, Flush_IFID, Flush_IDEX, Trap, Halted, Redirect_Cnt
    );
endinterface

// File: rtl/pc_redirect_unit_sat_counter.sv
// Saturating up-counter with synchronous clear, used for redirect statistics.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pc_redirect_unit.sv
// Fetch PC owner: applies EX redirects, squashes wrong-path stages, holds on
// stall/imem busy, traps on illegal targets and counts taken redirects.
module pc_redirect_unit
    import pc_redirect_unit_pkg::*;
#(
    parameter int unsigned PC_W      = 9,
    parameter int unsigned RESET_PC  = 0,
    parameter int unsigned FLUSH_CYC = 2,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    pc_redirect_unit_if.slave bus
);

    localparam logic [1:0]      SQ_INIT = 2'(FLUSH_CYC - 1);
    localparam logic [PC_W-1:0] PC_RST  = PC_W'(RESET_PC);

    state_t          state_q, state_d;
    logic [1:0]      sq_q, sq_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;
    logic            ifid_q, ifid_d;
    logic            idex_q, idex_d;
    logic            trap_q, trap_d;
    logic            halted_q, halted_d;
    logic            redirect;
    logic            advance;

    assign advance = !bus.Stall && bus.imem_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_RUN;
            sq_q     <= '0;
            pc_q     <= PC_RST;
            valid_q  <= 1'b0;
            ifid_q   <= 1'b0;
            idex_q   <= 1'b0;
            trap_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sq_q     <= sq_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            ifid_q   <= ifid_d;
            idex_q   <= idex_d;
            trap_q   <= trap_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sq_d     = sq_q;
        pc_d     = pc_q;
        redirect = 1'b0;

        unique case (state_q)
            S_RUN: begin
                if (bus.PcSel && !is_legal_target(bus.BrPC, PC_W)) begin
                    state_d = S_TRAP;
                end else if (bus.PcSel) begin
                    redirect = 1'b1;
                    pc_d     = bus.BrPC[PC_W-1:0];
                    if (FLUSH_CYC > 1) begin
                        state_d = S_SQUASH;
                        sq_d    = SQ_INIT;
                    end
                end else if (bus.Halt) begin
                    state_d = S_HALTED;
                end else if (advance) begin
                    pc_d = pc_q + PC_W'(PC_INC);
                end
            end
            S_SQUASH: begin
                if (advance) begin
                    pc_d = pc_q + PC_W'(PC_INC);
                end
                sq_d = sq_q - 2'd1;
                if (sq_q == 2'd1) begin
                    state_d = S_RUN;
                end
            end
            default: begin
            end
        endcase

        // Outputs are registered, so they are derived from the next state;
        // IF/ID flush covers the redirect cycle plus every squash cycle.
        valid_d  = (state_d == S_RUN) || (state_d == S_SQUASH);
        ifid_d   = redirect || (state_q == S_SQUASH);
        idex_d   = redirect;
        trap_d   = (state_d == S_TRAP);
        halted_d = (state_d == S_HALTED);
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_redirect_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (redirect),
        .clear (1'b0),
        .count (bus.Redirect_Cnt)
    );

    assign bus.Cur_PC      = pc_q;
    assign bus.Fetch_Valid = valid_q;
    assign bus.Flush_IFID  = ifid_q;
    assign bus.Flush_IDEX  = idex_q;
    assign bus.Trap        = trap_q;
    assign bus.Halted      = halted_q;

endmodule
